node_traffic_injector: RTL and testbench
========================================

// Module: node_traffic_injector
// PURPOSE
// - Synthesizable per-node traffic source. One instance per node sits directly upstream of a network local input port.
// - Generates ant packets (packet_t, config.sv) at a fixed offered rate with LFSR-random destinations.
// - Buffers them in a local queue and injects them under the port's valid/enable handshake.
// - Replaces free-running testbench stimulus; counters expose offered, accepted and dropped load.
// PARAMETERS
// - X_LOC         0        node x coordinate, written to x_source
// - Y_LOC         0        node y coordinate, written to y_source
// - PACKET_RATE   2        offered load, percent of one packet/cycle, 0..100
// - QUEUE_DEPTH   32       injection queue entries, power of 2, >=2
// - LFSR_SEED     16'hACE1 non-zero LFSR reset value; differs per node
// PORTS
// - clk           in   1       clock
// - reset_n       in   1       synchronous active-low reset
// - i_gen_en      in   1       1 = generate traffic; 0 = stop generating and drain
// - i_en          in   1       network port can accept (network o_en[node])
// - o_data        out  packet_t  head-of-queue packet (network i_data[node])
// - o_data_val    out  1       o_data valid (network i_data_val[node])
// - o_level       out  $clog2(QUEUE_DEPTH)+1  queue occupancy
// - o_gen_count   out  16      packets enqueued, wraps
// - o_drop_count  out  16      packets dropped on full, saturates at 16'hFFFF
// - o_idle        out  1       FSM in IDLE and queue empty
// BEHAVIOUR
// - Clock and reset: one clock, clk. reset_n is synchronous, active-low, sampled on posedge clk. All state updates on posedge clk.
// - Reset values: o_data_val=0, o_data='0, o_level=0, counters=0, o_idle=1, FSM=IDLE, rate acc=0, LFSR=LFSR_SEED, cycle counter=0, next id=0.
// - Handshake: transfer occurs on an edge where o_data_val && i_en.
//   - o_data must hold stable while o_data_val=1 && i_en=0.
//   - o_data_val never drops without a transfer, except on reset.
// - Rate: 7-bit accumulator, updated only in RUN.
//   - acc+PACKET_RATE>=100: generate one packet this cycle; acc <= acc+PACKET_RATE-100.
//   - Otherwise acc <= acc+PACKET_RATE.
//   - PACKET_RATE=0 never generates; 100 generates every RUN cycle.
// - Destination:
//   - 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle out of reset.
//   - x_dest = lfsr[7:0] % X_NODES; y_dest = lfsr[15:8] % Y_NODES.
//   - If dest == (X_LOC,Y_LOC), x_dest <= (X_LOC+1) % X_NODES. No self-traffic.
// - Packet fields:
//   - id = next id (8b, wraps 255->0); x/y_source = X_LOC/Y_LOC.
//   - ant=1, backward=0; all memories, num_memories, b_num_memories and measure = 0.
//   - timestamp = free-running cycle counter at generation, truncated to field width.
// - Enqueue:
//   - Generated packet is written at the same edge.
//   - id and o_gen_count increment only on enqueue.
// - Full:
//   - Full is judged on pre-edge occupancy. A packet generated while full is dropped, even if a dequeue occurs at that edge.
//   - On drop, o_drop_count increments and id does not advance.
// - Latency: packet generated in cycle t into an empty queue shows o_data_val=1 in cycle t+1 (show-ahead head register).
// - Simultaneous enqueue+dequeue when not full: level unchanged; order preserved (FIFO).
// - FSM:
//   - IDLE -> RUN when i_gen_en=1.
//   - RUN -> DRAIN when i_gen_en=0.
//   - DRAIN -> RUN when i_gen_en=1; acc is preserved.
//   - DRAIN -> IDLE when level==0.
//   - No generation in IDLE or DRAIN.
// - Reset mid-operation: queue flushed; in-flight head is discarded (o_data_val=0 next cycle); counters cleared.
// STRUCTURE
// - Shared package (config.sv):
//   - packet_t, X_NODES, Y_NODES, NODES, INPUT_QUEUE_DEPTH.
//   - New constants: RATE_DENOM=100, LFSR_TAPS=16'hB400.
// - Sub-module injection_fifo:
//   - Sync FIFO of packet_t with show-ahead output, full/empty/level flags.
//   - Same clk/reset_n; parameter DEPTH.
// - Top: FSM, rate accumulator, LFSR, cycle counter, id and drop/gen counters.
// TESTING
// - Reset at 4x4, PACKET_RATE=50, i_en=1, i_gen_en=1 for 100 cycles
//   -> o_gen_count=50, o_drop_count=0, ids 0..49 in order.
// - PACKET_RATE=100, QUEUE_DEPTH=4, i_en=0 for 10 RUN cycles
//   -> o_level=4, o_drop_count=6, o_data.id=0 held stable, o_data_val=1.
// - Drive a destination check on X_LOC=1, Y_LOC=2 over 1000 packets
//   -> every x_dest<X_NODES, y_dest<Y_NODES, never (1,2).
// - i_gen_en 1->0 with level=3, i_en=1
//   -> exactly 3 transfers, then o_idle=1, o_gen_count frozen.
// - reset_n=0 for one edge with level=3 mid-burst
//   -> next cycle o_data_val=0, o_level=0, counters=0, next packet id=0.
// - Full+dequeue same edge (QUEUE_DEPTH=4, level=4, i_en=1, generation)
//   -> drop counted, o_level=3.

Source files
------------

// File: rtl/node_traffic_injector_pkg.sv
// Shared definitions for the per-node traffic injector: mesh size, packet
// layout, injector FSM states and the destination LFSR step.
package node_traffic_injector_pkg;

  localparam int X_NODES           = 4;
  localparam int Y_NODES           = 4;
  localparam int NODES             = X_NODES * Y_NODES;
  localparam int INPUT_QUEUE_DEPTH = 4;

  localparam int          RATE_DENOM = 100;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;  // taps 16,14,13,11

  localparam int COORD_W      = 8;
  localparam int ID_W         = 8;
  localparam int TS_W         = 16;
  localparam int MAX_MEMORIES = 4;
  localparam int MEM_CNT_W    = 3;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } node_addr_t;

  typedef struct packed {
    logic [ID_W-1:0]                   id;
    coord_t                            x_source;
    coord_t                            y_source;
    coord_t                            x_dest;
    coord_t                            y_dest;
    logic                              ant;
    logic                              backward;
    node_addr_t [MAX_MEMORIES-1:0]     memories;
    logic [MEM_CNT_W-1:0]              num_memories;
    logic [MEM_CNT_W-1:0]              b_num_memories;
    logic                              measure;
    logic [TS_W-1:0]                   timestamp;
  } packet_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } inj_state_t;

  // Fibonacci step: new bit is the XOR of the tapped bits, shifted in at bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/node_traffic_injector_fifo.sv
// Synchronous show-ahead FIFO of packets for the injection queue.
// Ports: clk, reset_n (sync, active-low), wr_en/wr_data (push),
//        rd_en (pop head), rd_data (head, '0 when empty),
//        full, empty, level (occupancy 0..DEPTH).
module node_traffic_injector_fifo
  import node_traffic_injector_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  packet_t                  wr_data,
  input  logic                     rd_en,
  output packet_t                  rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  packet_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   count;
  logic            do_wr;
  logic            do_rd;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  // Head is visible combinationally from storage, so a push into an empty
  // queue is presented the very next cycle.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + LW'(do_wr) - LW'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/node_traffic_injector.sv
// Per-node traffic source: generates ant packets at a fixed offered rate
// with LFSR-chosen destinations, queues them and injects them into the
// network local port under the valid/enable handshake.
// Ports: clk, reset_n (sync, active-low), i_gen_en (run/stop generation),
//        i_en (port ready), o_data/o_data_val (head packet), o_level
//        (queue occupancy), o_gen_count (enqueued, wraps), o_drop_count
//        (dropped on full, saturates), o_idle (IDLE and queue empty).
//
// state    | meaning
// ST_IDLE  | no generation, waiting for i_gen_en
// ST_RUN   | rate accumulator active, packets generated
// ST_DRAIN | generation stopped, queue emptying into the network
module node_traffic_injector
  import node_traffic_injector_pkg::*;
#(
  parameter int unsigned X_LOC       = 0,
  parameter int unsigned Y_LOC       = 0,
  parameter int unsigned PACKET_RATE = 2,
  parameter int unsigned QUEUE_DEPTH = 32,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           i_gen_en,
  input  logic                           i_en,
  output packet_t                        o_data,
  output logic                           o_data_val,
  output logic [$clog2(QUEUE_DEPTH):0]   o_level,
  output logic [15:0]                    o_gen_count,
  output logic [15:0]                    o_drop_count,
  output logic                           o_idle
);

  localparam coord_t X_N   = coord_t'(X_NODES);
  localparam coord_t Y_N   = coord_t'(Y_NODES);
  localparam coord_t X_SRC = coord_t'(X_LOC);
  localparam coord_t Y_SRC = coord_t'(Y_LOC);
  localparam coord_t X_ALT = coord_t'((X_LOC + 1) % X_NODES);

  inj_state_t        state_q;
  logic [6:0]        acc_q;
  logic [15:0]       lfsr_q;
  logic [TS_W-1:0]   cycle_q;
  logic [ID_W-1:0]   id_q;
  logic [15:0]       gen_count_q;
  logic [15:0]       drop_count_q;

  logic [7:0]        rate_sum;
  logic              gen_fire;
  logic              fifo_full;
  logic              fifo_empty;
  logic              wr_en;
  logic              drop;
  coord_t            x_raw;
  coord_t            y_raw;
  packet_t           new_pkt;

  assign rate_sum = {1'b0, acc_q} + 8'(PACKET_RATE);
  assign gen_fire = (state_q == ST_RUN) && (rate_sum >= 8'(RATE_DENOM));
  // Full is judged on the occupancy before this edge; a same-edge pop does
  // not make room for the packet generated at that edge.
  assign wr_en    = gen_fire && !fifo_full;
  assign drop     = gen_fire && fifo_full;

  assign x_raw = lfsr_q[7:0]  % X_N;
  assign y_raw = lfsr_q[15:8] % Y_N;

  always_comb begin
    new_pkt           = '0;
    new_pkt.id        = id_q;
    new_pkt.x_source  = X_SRC;
    new_pkt.y_source  = Y_SRC;
    new_pkt.x_dest    = x_raw;
    new_pkt.y_dest    = y_raw;
    new_pkt.ant       = 1'b1;
    new_pkt.timestamp = cycle_q;
    if ((x_raw == X_SRC) && (y_raw == Y_SRC)) new_pkt.x_dest = X_ALT;
  end

  node_traffic_injector_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_injection_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_data (new_pkt),
    .rd_en   (o_data_val && i_en),
    .rd_data (o_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (o_level)
  );

  assign o_data_val   = !fifo_empty;
  assign o_gen_count  = gen_count_q;
  assign o_drop_count = drop_count_q;
  assign o_idle       = (state_q == ST_IDLE) && fifo_empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      lfsr_q       <= LFSR_SEED;
      cycle_q      <= '0;
      id_q         <= '0;
      gen_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      lfsr_q  <= lfsr_next(lfsr_q);
      cycle_q <= cycle_q + 1'b1;

      if (state_q == ST_RUN)
        acc_q <= gen_fire ? 7'(rate_sum - 8'(RATE_DENOM)) : rate_sum[6:0];

      if (wr_en) begin
        id_q        <= id_q + 1'b1;
        gen_count_q <= gen_count_q + 16'd1;
      end

      if (drop && (drop_count_q != 16'hFFFF))
        drop_count_q <= drop_count_q + 16'd1;

      case (state_q)
        ST_IDLE:  if (i_gen_en) state_q <= ST_RUN;
        ST_RUN:   if (!i_gen_en) state_q <= ST_DRAIN;
        ST_DRAIN: begin
          if (i_gen_en)        state_q <= ST_RUN;
          else if (fifo_empty) state_q <= ST_IDLE;
        end
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_node_traffic_injector.sv
module tb_node_traffic_injector;
  import node_traffic_injector_pkg::*;

  // Instance A: node (0,0), 50% load, 32-deep queue.
  // Instance B: node (1,2), 100% load, 4-deep queue.
  localparam int          RATE  [2] = '{50, 100};
  localparam int          DEPTH [2] = '{32, 4};
  localparam int          XLOC  [2] = '{0, 1};
  localparam int          YLOC  [2] = '{0, 2};
  localparam logic [15:0] SEED  [2] = '{16'hACE1, 16'h1D2B};

  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n  [2];
  logic        gen_en [2];
  logic        en     [2];
  packet_t     od     [2];
  logic        ov     [2];
  logic [15:0] ogc    [2];
  logic [15:0] odc    [2];
  logic        oi     [2];
  logic [5:0]  lvl_a;
  logic [2:0]  lvl_b;

  node_traffic_injector #(
    .X_LOC(0), .Y_LOC(0), .PACKET_RATE(50), .QUEUE_DEPTH(32), .LFSR_SEED(16'hACE1)
  ) dut_a (
    .clk(clk), .reset_n(rst_n[0]), .i_gen_en(gen_en[0]), .i_en(en[0]),
    .o_data(od[0]), .o_data_val(ov[0]), .o_level(lvl_a),
    .o_gen_count(ogc[0]), .o_drop_count(odc[0]), .o_idle(oi[0])
  );

  node_traffic_injector #(
    .X_LOC(1), .Y_LOC(2), .PACKET_RATE(100), .QUEUE_DEPTH(4), .LFSR_SEED(16'h1D2B)
  ) dut_b (
    .clk(clk), .reset_n(rst_n[1]), .i_gen_en(gen_en[1]), .i_en(en[1]),
    .o_data(od[1]), .o_data_val(ov[1]), .o_level(lvl_b),
    .o_gen_count(ogc[1]), .o_drop_count(odc[1]), .o_idle(oi[1])
  );

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 1'b0;
  bit dest_on  = 1'b0;
  int n_dest   = 0;
  logic [7:0] obs_a[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_pkt(input string name, input packet_t act, input packet_t exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int level_of(input int d);
    return (d == 0) ? int'(lvl_a) : int'(lvl_b);
  endfunction

  // ---------------- behavioural model ----------------
  int          m_mode [2] = '{M_IDLE, M_IDLE};
  int          m_acc  [2] = '{0, 0};
  logic [15:0] m_lfsr [2] = '{16'h0, 16'h0};
  logic [15:0] m_cyc  [2] = '{16'h0, 16'h0};
  logic [7:0]  m_id   [2] = '{8'h0, 8'h0};
  logic [15:0] m_gen  [2] = '{16'h0, 16'h0};
  logic [15:0] m_drop [2] = '{16'h0, 16'h0};
  packet_t     m_q    [2][$];

  task automatic model_step(input int d);
    packet_t     p;
    int          pre, xd, yd;
    bit          make;
    logic [15:0] s;
    if (!rst_n[d]) begin
      m_mode[d] = M_IDLE; m_acc[d] = 0; m_lfsr[d] = SEED[d]; m_cyc[d] = '0;
      m_id[d] = '0; m_gen[d] = '0; m_drop[d] = '0; m_q[d].delete();
      return;
    end
    make = 1'b0;
    if (m_mode[d] == M_RUN) begin
      m_acc[d] = m_acc[d] + RATE[d];
      if (m_acc[d] >= 100) begin
        make = 1'b1;
        m_acc[d] = m_acc[d] - 100;
      end
    end
    pre = m_q[d].size();
    s   = m_lfsr[d];
    xd  = int'(s[7:0]) % X_NODES;
    yd  = int'(s[15:8]) % Y_NODES;
    if (xd == XLOC[d] && yd == YLOC[d]) xd = (XLOC[d] + 1) % X_NODES;
    p = '0;
    p.id = m_id[d];
    p.x_source = 8'(XLOC[d]);
    p.y_source = 8'(YLOC[d]);
    p.x_dest = 8'(xd);
    p.y_dest = 8'(yd);
    p.ant = 1'b1;
    p.timestamp = m_cyc[d];
    if (pre > 0 && en[d]) void'(m_q[d].pop_front());
    if (make) begin
      if (pre >= DEPTH[d]) begin
        if (m_drop[d] != 16'hFFFF) m_drop[d] = m_drop[d] + 16'd1;
      end else begin
        m_q[d].push_back(p);
        m_id[d]  = m_id[d] + 8'd1;
        m_gen[d] = m_gen[d] + 16'd1;
      end
    end
    case (m_mode[d])
      M_IDLE:  if (gen_en[d]) m_mode[d] = M_RUN;
      M_RUN:   if (!gen_en[d]) m_mode[d] = M_DRAIN;
      default: if (gen_en[d]) m_mode[d] = M_RUN; else if (pre == 0) m_mode[d] = M_IDLE;
    endcase
    m_lfsr[d] = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    m_cyc[d]  = m_cyc[d] + 16'd1;
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        string nm;
        nm = (d == 0) ? "A" : "B";
        chk({nm, ".val"},   ov[d],  m_q[d].size() > 0);
        chk({nm, ".level"}, level_of(d), m_q[d].size());
        chk({nm, ".gen"},   ogc[d], m_gen[d]);
        chk({nm, ".drop"},  odc[d], m_drop[d]);
        chk({nm, ".idle"},  oi[d],  (m_mode[d] == M_IDLE) && (m_q[d].size() == 0));
        if (m_q[d].size() > 0) chk_pkt({nm, ".data"}, od[d], m_q[d][0]);
      end
    end
  end

  // Transfer monitors: inputs change only just after posedge, so at negedge
  // val && en predicts a transfer at the coming edge.
  always @(negedge clk) begin
    if (chk_on && ov[0] && en[0]) obs_a.push_back(od[0].id);
    if (chk_on && dest_on && ov[1] && en[1]) begin
      chk("B.x_dest_range", od[1].x_dest < 8'(X_NODES), 1);
      chk("B.y_dest_range", od[1].y_dest < 8'(Y_NODES), 1);
      chk("B.no_self", (od[1].x_dest == 8'd1) && (od[1].y_dest == 8'd2), 0);
      n_dest++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit seen;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; gen_en[d] = 1'b0; en[d] = 1'b0;
    end
    cyc(2);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    chk_on = 1'b1;

    // reset state
    chk("A.rst_val",   ov[0], 0);
    chk("A.rst_level", lvl_a, 0);
    chk("A.rst_idle",  oi[0], 1);
    chk("A.rst_gen",   ogc[0], 0);
    chk("A.rst_data",  od[0], 0);

    // 50% load, port always ready, 100 RUN cycles
    en[0] = 1'b1; gen_en[0] = 1'b1;
    cyc(101);
    chk("A.gen_100", ogc[0], 50);
    chk("A.drop_100", odc[0], 0);
    gen_en[0] = 1'b0;
    cyc(10);
    chk("A.n_transfers", obs_a.size(), 50);
    for (int k = 0; k < obs_a.size() && k < 50; k++) chk("A.id_order", obs_a[k], k);
    chk("A.idle_after", oi[0], 1);

    // build level 3 with port blocked, then stop and drain
    en[0] = 1'b0; gen_en[0] = 1'b1;
    cyc(6);
    chk("A.level3", lvl_a, 3);
    chk("A.gen53", ogc[0], 53);
    gen_en[0] = 1'b0; en[0] = 1'b1;
    base = obs_a.size();
    cyc(10);
    chk("A.drain_transfers", obs_a.size() - base, 3);
    chk("A.drain_idle", oi[0], 1);
    chk("A.drain_gen_frozen", ogc[0], 53);

    // reset mid-burst
    en[0] = 1'b0; gen_en[0] = 1'b1;
    cyc(6);
    chk("A.pre_rst_level", lvl_a, 3);
    rst_n[0] = 1'b0;
    cyc(1);
    chk("A.mid_rst_val", ov[0], 0);
    chk("A.mid_rst_level", lvl_a, 0);
    chk("A.mid_rst_gen", ogc[0], 0);
    chk("A.mid_rst_drop", odc[0], 0);
    rst_n[0] = 1'b1; en[0] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cyc(1);
      seen = ov[0];
    end
    chk("A.first_val_seen", seen, 1);
    chk("A.first_id", od[0].id, 0);
    chk("A.first_ts", od[0].timestamp, 2);
    gen_en[0] = 1'b0;

    // B: 100% load into a blocked port
    gen_en[1] = 1'b1; en[1] = 1'b0;
    cyc(11);
    chk("B.full_level", lvl_b, 4);
    chk("B.full_drop", odc[1], 6);
    chk("B.full_gen", ogc[1], 4);
    chk("B.full_head_id", od[1].id, 0);
    chk("B.full_val", ov[1], 1);

    // full + dequeue at the same edge still drops
    en[1] = 1'b1;
    cyc(1);
    chk("B.fd_drop", odc[1], 7);
    chk("B.fd_level", lvl_b, 3);
    chk("B.fd_head_id", od[1].id, 1);

    // destination sweep
    dest_on = 1'b1;
    cyc(1100);
    dest_on = 1'b0;
    chk("B.dest_count", n_dest >= 1000, 1);
    gen_en[1] = 1'b0;
    cyc(10);
    chk("B.final_idle", oi[1], 1);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
